thor2022_commit_sched: RTL and testbench
========================================

Name: thor2022_commit_sched

Overview:
- Commit scheduler for the 8-entry reorder buffer (REB).
- Walks the REB head in order and retires up to two completed entries per clock.
- Drives the commit0/commit1 id/wr/tgt signals consumed by the register-file valid logic.
- Serialises exceptions through a request/acknowledge handshake with the exception unit, and keeps a retired-instruction count.

Parameters:
- REB_ENTRIES, 8, number of REB entries; power of two; ids are log2(REB_ENTRIES)=3 bits.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ent_v  in  8  REB entry holds a live instruction.
- ent_done  in  8  entry result complete.
- ent_exc  in  8  entry completed with exception (meaningful only when ent_done).
- ent_rfwr  in  8  entry writes a GPR.
- ent_tgt  in  48  6-bit target per entry; entry n at bits [6n+5:6n].
- stall  in  1  register-file write port unavailable; no commit this cycle.
- exc_ack  in  1  exception unit has taken the exception.
- commit0_v / commit1_v  out  1  slot carries a retiring entry.
- commit0_id / commit1_id  out  3  REB id retired.
- commit0_wr / commit1_wr  out  1  register write enable.
- commit0_tgt / commit1_tgt  out  6  target register.
- retire_mask  out  8  one-hot-or-two-hot set of entries freed this cycle.
- head  out  3  current oldest REB id.
- exc_req  out  1  exception pending at head.
- exc_id  out  3  id of excepting entry.
- retired_cnt  out  CNT_W  running count of retired entries, wraps.

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-high on rst.
- Reset values: all outputs 0; head=0; FSM=RUN. Reset mid-handshake abandons the exception; exc_req drops immediately.
- Registered outputs: all outputs are registered. Commit decisions are made from cycle-t inputs; commit* and retire_mask are visible at t+1, and head advances on the same edge.
- Slot 0 eligible when: FSM=RUN, !stall, ent_v[head], ent_done[head], !ent_exc[head].
- Slot 1 eligible when: slot 0 eligible, and h1=(head+1) mod 8 has ent_v, ent_done and !ent_exc.
- Head advance: by the number of slots committed (0, 1 or 2), modulo 8; 7+1→0, 6+2→0, 7+2→1.
- Write enable: commitN_wr = ent_rfwr & (tgt!=0). r0 is never written.
- Same target in both slots: if both slots write the same tgt, commit0_wr=0 and commit1_wr=1 (younger wins); commit0_v stays 1.
- Idle slots: a slot with v=0 drives id=0, wr=0, tgt=0.
- retire_mask: bit set for each committed id.
- retired_cnt: increments by 0/1/2 per cycle, modulo 2^CNT_W. An exception-retired entry also counts.
- FSM states:
  - RUN: normal commit. If ent_v[head] & ent_done[head] & ent_exc[head] & !stall → go to EXC. Slot 0 does not commit that cycle and nothing younger commits. Register exc_req=1, exc_id=head.
  - EXC: no commits; exc_req held 1. On exc_ack → go to FLUSH; exc_req drops next cycle.
  - FLUSH (one cycle):
    - Retire the excepting entry: commit0_v=1, wr=0, retire_mask bit set, head+1.
    - Then return to RUN.
- Handshake rule: exc_ack is ignored outside EXC. exc_ack asserted in the same cycle exc_req rises is honoured.
- stall: freezes commit in RUN only. EXC and FLUSH ignore stall.
- Flushed entries: an entry that drops ent_v (branch flush by REB owner) is simply never eligible. The scheduler does not track the tail. Empty REB (ent_v[head]=0) → no commit, head holds.

Test Plan:
1. Reset with entries 0,1 done, writing r5, r9 → first cycle after reset: no commit. Next cycle: commit0 id0 tgt5 wr1, commit1 id1 tgt9 wr1, retire_mask=8'h03, head=2, retired_cnt=2.
2. head=7, entries 7 and 0 done → commit ids 7,0, retire_mask=8'h81, head=1. Then head=6, entries 6,7 done → head=0.
3. Both slots target r12 → commit0_wr=0, commit1_wr=1. Both targets r0 → both wr=0, both v=1.
4. head=3 done with exc, entry 4 done → exc_req=1, exc_id=3, no commits for 3 cycles. exc_ack at cycle 4 → one cycle later commit0 id3 wr0, head=4. Following cycle entry 4 commits.
5. stall=1 for 4 cycles with head done → no commits, head steady. stall=0 → commit resumes next edge.
6. Assert rst asynchronously mid-EXC → exc_req and all outputs 0 before next clk edge, head=0, FSM=RUN.

Source files
------------

// File: rtl/thor2022_commit_sched_if.sv
// Commit scheduler bus: REB status in, commit slots,
// exception handshake and retire bookkeeping out.
interface thor2022_commit_sched_if #(
  parameter int REB_ENTRIES = 8,
  parameter int CNT_W       = 16
);
  localparam int IW = $clog2(REB_ENTRIES);

  logic [REB_ENTRIES-1:0]   ent_v;
  logic [REB_ENTRIES-1:0]   ent_done;
  logic [REB_ENTRIES-1:0]   ent_exc;
  logic [REB_ENTRIES-1:0]   ent_rfwr;
  logic [6*REB_ENTRIES-1:0] ent_tgt;
  logic                     stall;
  logic                     exc_ack;

  logic                     commit0_v;
  logic [IW-1:0]            commit0_id;
  logic                     commit0_wr;
  logic [5:0]               commit0_tgt;
  logic                     commit1_v;
  logic [IW-1:0]            commit1_id;
  logic                     commit1_wr;
  logic [5:0]               commit1_tgt;
  logic [REB_ENTRIES-1:0]   retire_mask;
  logic [IW-1:0]            head;
  logic                     exc_req;
  logic [IW-1:0]            exc_id;
  logic [CNT_W-1:0]         retired_cnt;

  modport master (
    output ent_v, ent_done, ent_exc,
    output ent_rfwr, ent_tgt,
    output stall, exc_ack,
    input  commit0_v, commit0_id,
    input  commit0_wr, commit0_tgt,
    input  commit1_v, commit1_id,
    input  commit1_wr, commit1_tgt,
    input  retire_mask, head,
    input  exc_req, exc_id, retired_cnt
  );

  modport slave (
    input  ent_v, ent_done, ent_exc,
    input  ent_rfwr, ent_tgt,
    input  stall, exc_ack,
    output commit0_v, commit0_id,
    output commit0_wr, commit0_tgt,
    output commit1_v, commit1_id,
    output commit1_wr, commit1_tgt,
    output retire_mask, head,
    output exc_req, exc_id, retired_cnt
  );
endinterface

// File: rtl/thor2022_commit_sched.sv
// In-order REB commit scheduler: two retire slots per
// clock, exceptions serialised through req/ack.
module thor2022_commit_sched #(
  parameter int REB_ENTRIES = 8,
  parameter int CNT_W       = 16
) (
  input logic clk,
  input logic rst,
  thor2022_commit_sched_if.slave bus
);
  localparam int IW = $clog2(REB_ENTRIES);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    EXC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;

  logic [IW-1:0]          hd;
  logic [IW-1:0]          h1;
  logic [5:0]             t0;
  logic [5:0]             t1;
  logic                   run;
  logic                   rdy0;
  logic                   ok0;
  logic                   ok1;
  logic                   go_exc;
  logic                   wr0;
  logic                   wr1;
  logic [1:0]             n;
  logic [REB_ENTRIES-1:0] hot0;
  logic [REB_ENTRIES-1:0] mask;

  assign hd = bus.head;

  always_comb begin
    h1     = hd + IW'(1);
    t0     = bus.ent_tgt[hd*6 +: 6];
    t1     = bus.ent_tgt[h1*6 +: 6];
    run    = (state == RUN) && !bus.stall;
    rdy0   = bus.ent_v[hd] && bus.ent_done[hd];
    ok0    = run && rdy0 && !bus.ent_exc[hd];
    go_exc = run && rdy0 && bus.ent_exc[hd];
    ok1    = ok0 && bus.ent_v[h1]
          && bus.ent_done[h1] && !bus.ent_exc[h1];
    wr0    = bus.ent_rfwr[hd] && (t0 != 6'd0);
    wr1    = bus.ent_rfwr[h1] && (t1 != 6'd0);
    // younger write wins when both slots hit one register
    if (ok1 && wr0 && wr1 && (t0 == t1))
      wr0 = 1'b0;
    n = ok1 ? 2'd2 : (ok0 ? 2'd1 : 2'd0);
    hot0     = '0;
    hot0[hd] = 1'b1;
    mask     = '0;
    if (ok0) mask[hd] = 1'b1;
    if (ok1) mask[h1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      bus.commit0_v   <= 1'b0;
      bus.commit0_id  <= '0;
      bus.commit0_wr  <= 1'b0;
      bus.commit0_tgt <= '0;
      bus.commit1_v   <= 1'b0;
      bus.commit1_id  <= '0;
      bus.commit1_wr  <= 1'b0;
      bus.commit1_tgt <= '0;
      bus.retire_mask <= '0;
      bus.head        <= '0;
      bus.exc_req     <= 1'b0;
      bus.exc_id      <= '0;
      bus.retired_cnt <= '0;
    end else begin
      bus.commit0_v   <= 1'b0;
      bus.commit0_id  <= '0;
      bus.commit0_wr  <= 1'b0;
      bus.commit0_tgt <= '0;
      bus.commit1_v   <= 1'b0;
      bus.commit1_id  <= '0;
      bus.commit1_wr  <= 1'b0;
      bus.commit1_tgt <= '0;
      bus.retire_mask <= '0;
      unique case (state)
        RUN: begin
          if (ok0) begin
            bus.commit0_v   <= 1'b1;
            bus.commit0_id  <= hd;
            bus.commit0_wr  <= wr0;
            bus.commit0_tgt <= t0;
            if (ok1) begin
              bus.commit1_v   <= 1'b1;
              bus.commit1_id  <= h1;
              bus.commit1_wr  <= wr1;
              bus.commit1_tgt <= t1;
            end
            bus.retire_mask <= mask;
            bus.head        <= hd + IW'(n);
            bus.retired_cnt <= bus.retired_cnt
                             + CNT_W'(n);
          end else if (go_exc) begin
            state       <= EXC;
            bus.exc_req <= 1'b1;
            bus.exc_id  <= hd;
          end
        end
        EXC: begin
          if (bus.exc_ack) begin
            state       <= FLUSH;
            bus.exc_req <= 1'b0;
          end
        end
        FLUSH: begin
          // retire the faulting entry without a write
          bus.commit0_v   <= 1'b1;
          bus.commit0_id  <= hd;
          bus.commit0_tgt <= t0;
          bus.retire_mask <= hot0;
          bus.head        <= h1;
          bus.retired_cnt <= bus.retired_cnt
                           + CNT_W'(1);
          state           <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_thor2022_commit_sched.sv
// Directed bench for the REB commit scheduler:
// dual retire, wrap, write arbitration, exceptions, stall, reset.
module tb_thor2022_commit_sched;
  logic clk;
  logic rst;
  int   nvec;
  int   nerr;
  logic [2:0]  exp_head;
  logic [15:0] exp_cnt;

  thor2022_commit_sched_if #(
    .REB_ENTRIES(8), .CNT_W(16)
  ) bus ();

  thor2022_commit_sched #(
    .REB_ENTRIES(8), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ents();
    bus.ent_v    = '0;
    bus.ent_done = '0;
    bus.ent_exc  = '0;
    bus.ent_rfwr = '0;
    bus.ent_tgt  = '0;
  endtask

  task automatic set_ent(input int idx, input logic wr,
                         input logic [5:0] tgt,
                         input logic exc);
    bus.ent_v[idx]           = 1'b1;
    bus.ent_done[idx]        = 1'b1;
    bus.ent_exc[idx]         = exc;
    bus.ent_rfwr[idx]        = wr;
    bus.ent_tgt[idx*6 +: 6]  = tgt;
  endtask

  task automatic advance(input logic [2:0] target);
    int guard;
    guard = 0;
    while (exp_head != target && guard < 16) begin
      clear_ents();
      set_ent(int'(exp_head), 1'b0, 6'd0, 1'b0);
      step();
      exp_head = exp_head + 3'd1;
      exp_cnt  = exp_cnt + 16'd1;
      guard++;
      nvec++;
      if (bus.head !== exp_head ||
          bus.retired_cnt !== exp_cnt) begin
        nerr++;
        $display("FAIL advance head/cnt got %0d/%0d want %0d/%0d",
                 bus.head, bus.retired_cnt, exp_head, exp_cnt);
      end
    end
    clear_ents();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.exc_ack = 1'b0;
    clear_ents();
    set_ent(0, 1'b1, 6'd5, 1'b0);
    set_ent(1, 1'b1, 6'd9, 1'b0);
    step();
    step();
    nvec++;
    if (bus.commit0_v !== 1'b0 || bus.commit1_v !== 1'b0 ||
        bus.head !== 3'd0 || bus.retire_mask !== 8'h00 ||
        bus.exc_req !== 1'b0 || bus.retired_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_state got v%b%b h%0d m%h cnt%0d",
               bus.commit0_v, bus.commit1_v, bus.head,
               bus.retire_mask, bus.retired_cnt);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if (bus.commit0_v !== 1'b0 || bus.head !== 3'd0) begin
      nerr++;
      $display("FAIL first_cycle got v%b h%0d want v0 h0",
               bus.commit0_v, bus.head);
    end
    step();
    exp_head = 3'd2;
    exp_cnt  = 16'd2;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_id !== 3'd0 ||
        bus.commit0_tgt !== 6'd5 || bus.commit0_wr !== 1'b1 ||
        bus.commit1_v !== 1'b1 || bus.commit1_id !== 3'd1 ||
        bus.commit1_tgt !== 6'd9 || bus.commit1_wr !== 1'b1) begin
      nerr++;
      $display("FAIL dual_commit got %b/%0d/%0d/%b %b/%0d/%0d/%b",
               bus.commit0_v, bus.commit0_id, bus.commit0_tgt,
               bus.commit0_wr, bus.commit1_v, bus.commit1_id,
               bus.commit1_tgt, bus.commit1_wr);
    end
    nvec++;
    if (bus.retire_mask !== 8'h03 || bus.head !== 3'd2 ||
        bus.retired_cnt !== 16'd2) begin
      nerr++;
      $display("FAIL dual_book got m%h h%0d c%0d want 03 2 2",
               bus.retire_mask, bus.head, bus.retired_cnt);
    end
    clear_ents();
    step();
    nvec++;
    if (bus.commit0_v !== 1'b0 || bus.commit0_id !== 3'd0 ||
        bus.commit0_tgt !== 6'd0 || bus.head !== 3'd2 ||
        bus.retire_mask !== 8'h00) begin
      nerr++;
      $display("FAIL empty_reb got v%b id%0d t%0d h%0d m%h",
               bus.commit0_v, bus.commit0_id, bus.commit0_tgt,
               bus.head, bus.retire_mask);
    end
  endtask

  task automatic test_wrap();
    advance(3'd7);
    set_ent(7, 1'b0, 6'd0, 1'b0);
    set_ent(0, 1'b0, 6'd0, 1'b0);
    step();
    exp_head = 3'd1;
    exp_cnt  = exp_cnt + 16'd2;
    nvec++;
    if (bus.commit0_id !== 3'd7 || bus.commit1_id !== 3'd0 ||
        bus.retire_mask !== 8'h81 || bus.head !== 3'd1 ||
        bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL wrap_7_0 got id%0d,%0d m%h h%0d c%0d",
               bus.commit0_id, bus.commit1_id, bus.retire_mask,
               bus.head, bus.retired_cnt);
    end
    advance(3'd6);
    set_ent(6, 1'b0, 6'd0, 1'b0);
    set_ent(7, 1'b0, 6'd0, 1'b0);
    step();
    exp_head = 3'd0;
    exp_cnt  = exp_cnt + 16'd2;
    nvec++;
    if (bus.retire_mask !== 8'hc0 || bus.head !== 3'd0 ||
        bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL wrap_6_2 got m%h h%0d c%0d want c0 0 %0d",
               bus.retire_mask, bus.head, bus.retired_cnt, exp_cnt);
    end
    advance(3'd7);
    set_ent(7, 1'b0, 6'd0, 1'b0);
    set_ent(0, 1'b0, 6'd0, 1'b0);
    set_ent(1, 1'b0, 6'd0, 1'b0);
    step();
    exp_head = 3'd1;
    exp_cnt  = exp_cnt + 16'd2;
    nvec++;
    if (bus.head !== 3'd1 || bus.retire_mask !== 8'h81 ||
        bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL wrap_7_2 got h%0d m%h c%0d want 1 81 %0d",
               bus.head, bus.retire_mask, bus.retired_cnt, exp_cnt);
    end
    clear_ents();
  endtask

  task automatic test_same_tgt();
    set_ent(1, 1'b1, 6'd12, 1'b0);
    set_ent(2, 1'b1, 6'd12, 1'b0);
    step();
    exp_head = 3'd3;
    exp_cnt  = exp_cnt + 16'd2;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_wr !== 1'b0 ||
        bus.commit1_v !== 1'b1 || bus.commit1_wr !== 1'b1 ||
        bus.commit1_tgt !== 6'd12 || bus.head !== 3'd3) begin
      nerr++;
      $display("FAIL same_tgt got v%b%b wr%b%b t%0d h%0d",
               bus.commit0_v, bus.commit1_v, bus.commit0_wr,
               bus.commit1_wr, bus.commit1_tgt, bus.head);
    end
    clear_ents();
    set_ent(3, 1'b1, 6'd0, 1'b0);
    set_ent(4, 1'b1, 6'd0, 1'b0);
    step();
    exp_head = 3'd5;
    exp_cnt  = exp_cnt + 16'd2;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_wr !== 1'b0 ||
        bus.commit1_v !== 1'b1 || bus.commit1_wr !== 1'b0 ||
        bus.head !== 3'd5 || bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL r0_tgt got v%b%b wr%b%b h%0d c%0d",
               bus.commit0_v, bus.commit1_v, bus.commit0_wr,
               bus.commit1_wr, bus.head, bus.retired_cnt);
    end
    clear_ents();
  endtask

  task automatic test_exception();
    advance(3'd3);
    set_ent(3, 1'b1, 6'd2, 1'b1);
    set_ent(4, 1'b1, 6'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++;
      if (bus.exc_req !== 1'b1 || bus.exc_id !== 3'd3 ||
          bus.commit0_v !== 1'b0 || bus.commit1_v !== 1'b0 ||
          bus.head !== 3'd3) begin
        nerr++;
        $display("FAIL exc_hold%0d got r%b id%0d v%b%b h%0d", i,
                 bus.exc_req, bus.exc_id, bus.commit0_v,
                 bus.commit1_v, bus.head);
      end
    end
    bus.exc_ack = 1'b1;
    step();
    bus.exc_ack = 1'b0;
    nvec++;
    if (bus.exc_req !== 1'b0 || bus.commit0_v !== 1'b0) begin
      nerr++;
      $display("FAIL exc_ack got r%b v%b want r0 v0",
               bus.exc_req, bus.commit0_v);
    end
    step();
    exp_head = 3'd4;
    exp_cnt  = exp_cnt + 16'd1;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_id !== 3'd3 ||
        bus.commit0_wr !== 1'b0 || bus.commit1_v !== 1'b0 ||
        bus.retire_mask !== 8'h08 || bus.head !== 3'd4 ||
        bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL flush got v%b id%0d wr%b m%h h%0d c%0d",
               bus.commit0_v, bus.commit0_id, bus.commit0_wr,
               bus.retire_mask, bus.head, bus.retired_cnt);
    end
    step();
    exp_head = 3'd5;
    exp_cnt  = exp_cnt + 16'd1;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_id !== 3'd4 ||
        bus.commit0_wr !== 1'b1 || bus.commit0_tgt !== 6'd7 ||
        bus.head !== 3'd5 || bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL post_flush got v%b id%0d wr%b t%0d h%0d",
               bus.commit0_v, bus.commit0_id, bus.commit0_wr,
               bus.commit0_tgt, bus.head);
    end
    clear_ents();
  endtask

  task automatic test_stall();
    set_ent(5, 1'b1, 6'd3, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (bus.commit0_v !== 1'b0 || bus.head !== 3'd5 ||
          bus.retired_cnt !== exp_cnt) begin
        nerr++;
        $display("FAIL stall%0d got v%b h%0d c%0d", i,
                 bus.commit0_v, bus.head, bus.retired_cnt);
      end
    end
    bus.stall = 1'b0;
    step();
    exp_head = 3'd6;
    exp_cnt  = exp_cnt + 16'd1;
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_id !== 3'd5 ||
        bus.head !== 3'd6 || bus.retired_cnt !== exp_cnt) begin
      nerr++;
      $display("FAIL unstall got v%b id%0d h%0d c%0d",
               bus.commit0_v, bus.commit0_id, bus.head,
               bus.retired_cnt);
    end
    clear_ents();
  endtask

  task automatic test_async_reset();
    set_ent(6, 1'b1, 6'd4, 1'b1);
    step();
    nvec++;
    if (bus.exc_req !== 1'b1 || bus.exc_id !== 3'd6) begin
      nerr++;
      $display("FAIL exc_enter got r%b id%0d want r1 id6",
               bus.exc_req, bus.exc_id);
    end
    #2;
    rst = 1'b1;
    #1;
    nvec++;
    if (bus.exc_req !== 1'b0 || bus.exc_id !== 3'd0 ||
        bus.head !== 3'd0 || bus.retired_cnt !== 16'd0 ||
        bus.commit0_v !== 1'b0 || bus.retire_mask !== 8'h00) begin
      nerr++;
      $display("FAIL async_rst got r%b id%0d h%0d c%0d v%b",
               bus.exc_req, bus.exc_id, bus.head,
               bus.retired_cnt, bus.commit0_v);
    end
    clear_ents();
    step();
    rst = 1'b0;
    set_ent(0, 1'b1, 6'd3, 1'b0);
    step();
    nvec++;
    if (bus.commit0_v !== 1'b1 || bus.commit0_id !== 3'd0 ||
        bus.commit0_wr !== 1'b1 || bus.commit0_tgt !== 6'd3 ||
        bus.head !== 3'd1 || bus.retired_cnt !== 16'd1 ||
        bus.exc_req !== 1'b0) begin
      nerr++;
      $display("FAIL rst_run got v%b id%0d t%0d h%0d c%0d r%b",
               bus.commit0_v, bus.commit0_id, bus.commit0_tgt,
               bus.head, bus.retired_cnt, bus.exc_req);
    end
    clear_ents();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    exp_head = 3'd0;
    exp_cnt  = 16'd0;
    test_reset();
    test_wrap();
    test_same_tgt();
    test_exception();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
